sync_fifo_top: RTL
==================

// Module: sync_fifo_top
// PURPOSE
//  Single-clock, parametrised FIFO: successor to the dual-clock FIFO for same-domain buffering.
//  Adds programmable almost-full/almost-empty flags, occupancy count and sticky overflow/underflow errors.
//  Sits between a producer and a consumer in one clock domain.
//  Read data is registered and qualified by rvalid.
// PARAMETERS
//  WIDTH    16  data word width in bits
//  DEPTH    16  number of entries; power of 2, >= 4
//  AF_THR   12  almost_full asserted when count >= AF_THR (1..DEPTH-1)
//  AE_THR    4  almost_empty asserted when count <= AE_THR (1..DEPTH-1)
// PORTS
//  clk           in   1               single clock, all logic on posedge
//  rst           in   1               synchronous, active-high reset
//  wdata         in   WIDTH           write data
//  winc          in   1               write request
//  rinc          in   1               read request
//  err_clr       in   1               clears the sticky overflow/underflow flags
//  wfull         out  1               count == DEPTH
//  rempty        out  1               count == 0
//  almost_full   out  1               count >= AF_THR
//  almost_empty  out  1               count <= AE_THR
//  count         out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//  rdata         out  WIDTH           registered read data
//  rvalid        out  1               rdata holds the word popped in the previous cycle
//  overflow      out  1               sticky: a write was attempted while full and rejected
//  underflow     out  1               sticky: a read was attempted while empty and rejected
// BEHAVIOUR
//  - Reset (rst=1 at a posedge): pointers, count, rdata, rvalid, overflow and underflow go to 0.
//    Flags settle to rempty=1, almost_empty=1, wfull=0, almost_full=0.
//    Memory contents are not reset. Reset mid-operation discards all data; the cycle's winc/rinc are ignored.
//  - Pointers: ADDR_W=$clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0.
//    count is the only occupancy state.
//  - Write accept: wr_ok = winc & (~wfull | rd_ok).
//    On accept, mem[wptr] <= wdata and wptr increments.
//  - Read accept: rd_ok = rinc & ~rempty.
//    On accept, rdata <= mem[rptr], rptr increments and rvalid <= 1. Otherwise rvalid <= 0 and rdata holds.
//    Read latency is 1 cycle from the accepted rinc edge.
//  - Full and winc&rinc together: both are accepted and count is unchanged.
//  - Empty and winc&rinc together: the write is accepted, the read is rejected, underflow is set and count becomes 1.
//    There is no fall-through.
//  - count next = count + wr_ok - rd_ok.
//  - All flags decode from the registered count, so there is no combinational path from winc/rinc to any output.
//  - overflow <= 1 when winc & wfull & ~rd_ok. underflow <= 1 when rinc & rempty.
//    err_clr=1 clears both; a same-cycle set takes priority over the clear.
//  - Elaboration check ($error) when DEPTH is not a power of 2, or AF_THR/AE_THR is outside 1..DEPTH-1.
// STRUCTURE
//  - sync_fifo_pkg: clog2-based ADDR_W/CNT_W helper function and the threshold-check function.
//  - Sub-module sync_fifo_mem: simple dual-port RAM with 1 write port and 1 registered read port, WIDTH x DEPTH.
//    It infers BRAM or LUTRAM.
//  - sync_fifo_top holds the pointers, count, flag decode and error logic.
// TESTING (WIDTH=16, DEPTH=16, AF_THR=12, AE_THR=4)
//  1. Reset, then write 0..15 with no reads.
//     -> almost_empty drops after the 5th write. almost_full rises after the 12th. wfull=1, count=16 after the 16th.
//  2. From full, winc for one cycle.
//     -> word rejected, overflow=1 and stays 1. count stays 16. err_clr pulse -> overflow=0.
//  3. From full, read all 16.
//     -> rdata=0..15 in order, each 1 cycle after rinc, rvalid=1 on each. Then rempty=1, count=0.
//     One further rinc -> underflow=1, rvalid=0.
//  4. Continuous winc=rinc=1 for 40 cycles from empty, wdata incrementing from 0.
//     -> first read rejected (underflow set), count settles at 1.
//     rdata sequence is 0,1,2,... with no gaps or duplicates. Pointers wrap twice.
//  5. At full, winc=rinc=1 with wdata=0xBEEF.
//     -> both accepted, count stays 16, overflow stays 0. 0xBEEF is read out 16 pops later.
//  6. Fill to 9, assert rst for 1 cycle with winc=1.
//     -> next cycle count=0, rempty=1, rvalid=0. The in-flight write is not stored.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks for the single-clock FIFO.
package sync_fifo_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thr_ok(input int thr, input int depth);
    return (thr >= 1) && (thr <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port (BRAM/LUTRAM friendly).
module sync_fifo_mem #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read-before-write: a same-address write lands after this read samples.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO: pointers, occupancy count, flag decode and sticky error flags.
module sync_fifo_top
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int AF_THR = 12,
  parameter int AE_THR = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      winc,
  input  logic                      rinc,
  input  logic                      err_clr,
  output logic                      wfull,
  output logic                      rempty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THR);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_top: DEPTH must be a power of 2 and >= 4");
  end
  if (!thr_ok(AF_THR, DEPTH) || !thr_ok(AE_THR, DEPTH)) begin : g_bad_thr
    $error("sync_fifo_top: AF_THR/AE_THR must lie in 1..DEPTH-1");
  end

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rvalid_q, ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // Flags come only from registered count: no path from winc/rinc to outputs.
  assign wfull        = (count_q == FULL_C);
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A full FIFO may still accept a write when a read frees a slot this cycle.
  assign rd_ok = rinc & ~rempty;
  assign wr_ok = winc & (~wfull | rd_ok);

  always_comb begin
    wptr_d  = wr_ok ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d  = rd_ok ? rptr_q + ADDR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    ovf_d   = (winc & wfull & ~rd_ok) | (ovf_q & ~err_clr);
    udf_d   = (rinc & rempty)         | (udf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rvalid_q <= rd_ok;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_ok & ~rst),
    .waddr(wptr_q),
    .wdata(wdata),
    .re   (rd_ok & ~rst),
    .raddr(rptr_q),
    .rdata(rdata)
  );

  assign count     = count_q;
  assign rvalid    = rvalid_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
